// File: rtl/dcache_mem_stage.sv
// ============================================================================
// Module : dcache_mem_stage
// Direct-mapped, write-through, no-write-allocate MEM-stage data cache with
// 4-word block fills. Define DCACHE_STATS_EN to add hit/miss counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_mem_stage #(
  parameter int LINES = 32,
  parameter int WPB   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic        hit,
  output logic [31:0] readData,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);

  localparam int IW      = $clog2(LINES);
  localparam int TW      = 32 - 4 - IW;
  localparam int C_OFF_W = $clog2(WPB);

  localparam logic [C_OFF_W-1:0] c_LAST_BEAT = C_OFF_W'(WPB - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FILL  = 2'd1;
  localparam logic [1:0] c_WRITE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_stateNext;

  logic [LINES-1:0]   r_valid;
  logic [TW-1:0]      r_tag  [LINES];
  logic [31:0]        r_data [LINES][WPB];

  logic [31:0]        r_memAddr;
  logic [31:0]        r_memWdata;
  logic               r_memRead;
  logic               r_memWrite;
  logic [C_OFF_W-1:0] r_beat;

  logic [31:0]        w_memAddrNext;
  logic [31:0]        w_memWdataNext;
  logic               w_memReadNext;
  logic               w_memWriteNext;
  logic [C_OFF_W-1:0] w_beatNext;

  logic [TW-1:0]      w_tag;
  logic [IW-1:0]      w_index;
  logic [C_OFF_W-1:0] w_offset;
  logic [TW-1:0]      w_fillTag;
  logic [IW-1:0]      w_fillIndex;
  logic               w_lookupHit;
  logic               w_readHit;
  logic               w_isRead;
  logic               w_fillDone;
  logic               w_unusedAddrBits;

  assign w_tag            = address[31:4+IW];
  assign w_index          = address[4+IW-1:4];
  assign w_offset         = address[3:2];
  assign w_unusedAddrBits = ^address[1:0];

  // The fill address only moves within the block, so its index/tag are stable
  assign w_fillTag   = r_memAddr[31:4+IW];
  assign w_fillIndex = r_memAddr[4+IW-1:4];

  assign w_isRead    = MemRead & ~MemWrite;
  assign w_lookupHit = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_readHit   = (r_state == c_IDLE) && w_isRead && w_lookupHit;
  assign w_fillDone  = (r_state == c_FILL) && mem_ready && (r_beat == c_LAST_BEAT);

  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign mem_read  = r_memRead;
  assign mem_write = r_memWrite;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      c_IDLE: begin
        if (MemWrite) begin
          w_stateNext = c_WRITE;
        end else if (MemRead && !w_lookupHit) begin
          w_stateNext = c_FILL;
        end
      end
      c_FILL: begin
        if (w_fillDone) begin
          w_stateNext = c_IDLE;
        end
      end
      c_WRITE: begin
        if (mem_ready) begin
          w_stateNext = c_IDLE;
        end
      end
      default: w_stateNext = c_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    w_memAddrNext  = r_memAddr;
    w_memWdataNext = r_memWdata;
    w_memReadNext  = r_memRead;
    w_memWriteNext = r_memWrite;
    w_beatNext     = r_beat;
    hit            = 1'b0;
    readData       = 32'd0;

    case (r_state)
      c_IDLE: begin
        if (MemWrite) begin
          w_memAddrNext  = {address[31:2], 2'b00};
          w_memWdataNext = writeData;
          w_memWriteNext = 1'b1;
        end else if (MemRead && !w_lookupHit) begin
          w_memAddrNext = {address[31:4], 4'b0000};
          w_memReadNext = 1'b1;
          w_beatNext    = '0;
        end
        if (w_readHit) begin
          hit      = 1'b1;
          readData = r_data[w_index][w_offset];
        end
      end
      c_FILL: begin
        if (mem_ready) begin
          w_beatNext = r_beat + C_OFF_W'(1);
          if (r_beat == c_LAST_BEAT) begin
            w_memReadNext = 1'b0;
          end else begin
            w_memAddrNext = r_memAddr + 32'd4;
          end
        end
      end
      c_WRITE: begin
        if (mem_ready) begin
          w_memWriteNext = 1'b0;
          hit            = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign stall = (MemRead | MemWrite) & ~hit;

  // Reset aborts any outstanding transaction and drops both strobes at once
  always_ff @(posedge clk) begin
    if (reset) begin
      r_memAddr  <= 32'd0;
      r_memWdata <= 32'd0;
      r_memRead  <= 1'b0;
      r_memWrite <= 1'b0;
      r_beat     <= '0;
    end else begin
      r_memAddr  <= w_memAddrNext;
      r_memWdata <= w_memWdataNext;
      r_memRead  <= w_memReadNext;
      r_memWrite <= w_memWriteNext;
      r_beat     <= w_beatNext;
    end
  end

  // -------------------------------------------------------------- line store
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else if (w_fillDone) begin
      r_valid[w_fillIndex] <= 1'b1;
      r_tag[w_fillIndex]   <= w_fillTag;
    end
  end

  // Data array has no reset; a line becomes visible only through r_valid
  always_ff @(posedge clk) begin
    if (!reset) begin
      if ((r_state == c_IDLE) && MemWrite && w_lookupHit) begin
        r_data[w_index][w_offset] <= writeData;
      end else if ((r_state == c_FILL) && mem_ready) begin
        r_data[w_fillIndex][r_beat] <= mem_rdata;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits   <= 32'd0;
      stat_misses <= 32'd0;
    end else begin
      if (w_readHit && !stall && (stat_hits != 32'hFFFF_FFFF)) begin
        stat_hits <= stat_hits + 32'd1;
      end
      if ((r_state == c_IDLE) && (w_stateNext == c_FILL) && (stat_misses != 32'hFFFF_FFFF)) begin
        stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_mem_stage.sv
// ============================================================================
// Module : tb_dcache_mem_stage
// Directed self-checking bench for dcache_mem_stage with a 2-cycle-latency memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dcache_mem_stage;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        MemRead;
  logic        MemWrite;
  logic        hit;
  logic [31:0] readData;
  logic        stall;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  int checks = 0;
  int errors = 0;
  int expHits = 0;
  int expMisses = 0;
  int memCnt = 0;

  logic [31:0] wmem [logic [31:0]];
  logic [31:0] addrLog [$];

  dcache_mem_stage #(.LINES(32), .WPB(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .writeData (writeData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .hit       (hit),
    .readData  (readData),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (wmem.exists(a)) return wmem[a];
    return {16'hC0DE, a[15:0]};
  endfunction

  // Memory answers each strobe two cycles after it is seen, one beat at a time
  always @(negedge clk) begin
    if (reset) begin
      mem_ready = 1'b0;
      memCnt    = 0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
      memCnt    = (mem_read || mem_write) ? 1 : 0;
    end else if (mem_read || mem_write) begin
      memCnt = memCnt + 1;
      if (memCnt >= 2) begin
        memCnt    = 0;
        mem_ready = 1'b1;
        if (mem_write) wmem[mem_addr] = mem_wdata;
        else           mem_rdata = memWord(mem_addr);
      end
    end else begin
      memCnt = 0;
    end
  end

  // Issues one request and holds it until hit; records fill beats and stall
  task automatic runReq(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output int cycles,
                        output logic [31:0] rdata, output bit allStall,
                        output int writeCycles, output bit timedOut);
    @(negedge clk);
    address = a; writeData = wd; MemRead = rd; MemWrite = wr;
    addrLog.delete();
    cycles = 0; allStall = 1'b1; writeCycles = 0; timedOut = 1'b1; rdata = 32'd0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (mem_write) writeCycles++;
      if (hit) begin
        rdata = readData;
        timedOut = 1'b0;
        break;
      end
      if (!stall) allStall = 1'b0;
      if (mem_read && mem_ready) addrLog.push_back(mem_addr);
      cycles++;
      @(negedge clk);
    end
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    if (rd && !wr && !timedOut) begin
      expHits++;
      if (addrLog.size() != 0) expMisses++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (hit !== 1'b0)        begin errors++; $display("FAIL reset_hit: got %b want 0", hit); end
    checks++; if (readData !== 32'd0)  begin errors++; $display("FAIL reset_readData: got %h want 0", readData); end
    checks++; if (stall !== 1'b0)      begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (mem_read !== 1'b0)   begin errors++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
    checks++; if (mem_write !== 1'b0)  begin errors++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
    checks++; if (mem_addr !== 32'd0)  begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
`ifdef DCACHE_STATS_EN
    checks++; if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin
      errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_hits, stat_misses); end
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_read_miss_fill;
    int cyc, wc; logic [31:0] d; bit st, to;
    runReq(1'b1, 1'b0, 32'h40, 32'd0, cyc, d, st, wc, to);
    checks++; if (to)          begin errors++; $display("FAIL fill40_timeout: no hit within bound"); end
    checks++; if (cyc != 9)    begin errors++; $display("FAIL fill40_latency: got %0d want 9", cyc); end
    checks++; if (!st)         begin errors++; $display("FAIL fill40_stall: stall dropped before hit"); end
    checks++; if (addrLog.size() != 4) begin errors++; $display("FAIL fill40_beats: got %0d want 4", addrLog.size()); end
    if (addrLog.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (addrLog[i] !== 32'h40 + 32'(4 * i)) begin
          errors++; $display("FAIL fill40_addr%0d: got %h want %h", i, addrLog[i], 32'h40 + 32'(4 * i));
        end
      end
    end
    checks++; if (d !== 32'hC0DE0040) begin errors++; $display("FAIL fill40_data: got %h want C0DE0040", d); end
  endtask

  task automatic test_read_hit;
    int cyc, wc; logic [31:0] d; bit st, to;
    runReq(1'b1, 1'b0, 32'h48, 32'd0, cyc, d, st, wc, to);
    checks++; if (to || cyc != 0) begin errors++; $display("FAIL hit48_latency: got %0d want 0", cyc); end
    checks++; if (d !== 32'hC0DE0048) begin errors++; $display("FAIL hit48_data: got %h want C0DE0048", d); end
    checks++; if (addrLog.size() != 0) begin errors++; $display("FAIL hit48_memread: got %0d beats want 0", addrLog.size()); end
  endtask

  task automatic test_no_request;
    @(negedge clk);
    address = 32'h40; MemRead = 1'b0; MemWrite = 1'b0;
    #1;
    checks++; if (hit !== 1'b0)       begin errors++; $display("FAIL idle_hit: got %b want 0", hit); end
    checks++; if (readData !== 32'd0) begin errors++; $display("FAIL idle_readData: got %h want 0", readData); end
    checks++; if (stall !== 1'b0)     begin errors++; $display("FAIL idle_stall: got %b want 0", stall); end
  endtask

  task automatic test_write_hit;
    int cyc, wc; logic [31:0] d; bit st, to;
    runReq(1'b0, 1'b1, 32'h44, 32'hDEADBEEF, cyc, d, st, wc, to);
    checks++; if (to || cyc != 2) begin errors++; $display("FAIL wr44_latency: got %0d want 2", cyc); end
    checks++; if (wc != 2)        begin errors++; $display("FAIL wr44_strobe: got %0d want 2", wc); end
    checks++; if (d !== 32'd0)    begin errors++; $display("FAIL wr44_readData: got %h want 0", d); end
    checks++; if (memWord(32'h44) !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr44_memory: got %h want DEADBEEF", memWord(32'h44)); end
    runReq(1'b1, 1'b0, 32'h44, 32'd0, cyc, d, st, wc, to);
    checks++; if (to || cyc != 0)     begin errors++; $display("FAIL rd44_latency: got %0d want 0", cyc); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rd44_data: got %h want DEADBEEF", d); end
  endtask

  task automatic test_priority;
    int cyc, wc; logic [31:0] d; bit st, to;
    runReq(1'b1, 1'b1, 32'h48, 32'h12345678, cyc, d, st, wc, to);
    checks++; if (to || cyc != 2) begin errors++; $display("FAIL both48_latency: got %0d want 2", cyc); end
    checks++; if (memWord(32'h48) !== 32'h12345678) begin
      errors++; $display("FAIL both48_memory: got %h want 12345678", memWord(32'h48)); end
    runReq(1'b1, 1'b0, 32'h48, 32'd0, cyc, d, st, wc, to);
    checks++; if (to || cyc != 0)     begin errors++; $display("FAIL rd48_latency: got %0d want 0", cyc); end
    checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL rd48_data: got %h want 12345678", d); end
  endtask

  task automatic test_write_miss;
    int cyc, wc; logic [31:0] d; bit st, to;
    runReq(1'b0, 1'b1, 32'h1000, 32'hCAFEF00D, cyc, d, st, wc, to);
    checks++; if (to || cyc != 2) begin errors++; $display("FAIL wr1000_latency: got %0d want 2", cyc); end
    checks++; if (memWord(32'h1000) !== 32'hCAFEF00D) begin
      errors++; $display("FAIL wr1000_memory: got %h want CAFEF00D", memWord(32'h1000)); end
    runReq(1'b1, 1'b0, 32'h1000, 32'd0, cyc, d, st, wc, to);
    checks++; if (to || cyc != 9)     begin errors++; $display("FAIL rd1000_latency: got %0d want 9", cyc); end
    checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL rd1000_data: got %h want CAFEF00D", d); end
    runReq(1'b1, 1'b0, 32'h40, 32'd0, cyc, d, st, wc, to);
    checks++; if (to || cyc != 0)     begin errors++; $display("FAIL rd40_kept_latency: got %0d want 0", cyc); end
    checks++; if (d !== 32'hC0DE0040) begin errors++; $display("FAIL rd40_kept_data: got %h want C0DE0040", d); end
  endtask

  task automatic test_conflict;
    int cyc, wc; logic [31:0] d; bit st, to;
    runReq(1'b1, 1'b0, 32'h240, 32'd0, cyc, d, st, wc, to);
    checks++; if (to || cyc != 9)     begin errors++; $display("FAIL rd240_latency: got %0d want 9", cyc); end
    checks++; if (d !== 32'hC0DE0240) begin errors++; $display("FAIL rd240_data: got %h want C0DE0240", d); end
    runReq(1'b1, 1'b0, 32'h40, 32'd0, cyc, d, st, wc, to);
    checks++; if (to || cyc != 9)     begin errors++; $display("FAIL rd40_evicted_latency: got %0d want 9", cyc); end
    checks++; if (d !== 32'hC0DE0040) begin errors++; $display("FAIL rd40_evicted_data: got %h want C0DE0040", d); end
  endtask

  task automatic test_reset_during_fill;
    int cyc, wc, beats; logic [31:0] d; bit st, to;
    @(negedge clk);
    address = 32'h80; MemRead = 1'b1; beats = 0; to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (mem_read && mem_ready) beats++;
      if (beats == 2) begin to = 1'b0; break; end
      @(negedge clk);
    end
    checks++; if (to) begin errors++; $display("FAIL abort_timeout: got %0d beats want 2", beats); end
    @(negedge clk);
    reset = 1'b1; MemRead = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (mem_read !== 1'b0)  begin errors++; $display("FAIL abort_mem_read: got %b want 0", mem_read); end
    checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL abort_mem_addr: got %h want 0", mem_addr); end
`ifdef DCACHE_STATS_EN
    checks++; if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin
      errors++; $display("FAIL abort_stats: got %0d/%0d want 0/0", stat_hits, stat_misses); end
`endif
    @(negedge clk);
    reset = 1'b0; expHits = 0; expMisses = 0;
    runReq(1'b1, 1'b0, 32'h80, 32'd0, cyc, d, st, wc, to);
    checks++; if (to || cyc != 9) begin errors++; $display("FAIL refill80_latency: got %0d want 9", cyc); end
    checks++; if (addrLog.size() != 4) begin errors++; $display("FAIL refill80_beats: got %0d want 4", addrLog.size()); end
    if (addrLog.size() == 4) begin
      checks++; if (addrLog[0] !== 32'h80) begin errors++; $display("FAIL refill80_first: got %h want 80", addrLog[0]); end
      checks++; if (addrLog[3] !== 32'h8C) begin errors++; $display("FAIL refill80_last: got %h want 8C", addrLog[3]); end
    end
    checks++; if (d !== 32'hC0DE0080) begin errors++; $display("FAIL refill80_data: got %h want C0DE0080", d); end
    runReq(1'b1, 1'b0, 32'h44, 32'd0, cyc, d, st, wc, to);
    checks++; if (to || cyc != 9)     begin errors++; $display("FAIL rd44_inval_latency: got %0d want 9", cyc); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rd44_inval_data: got %h want DEADBEEF", d); end
  endtask

  task automatic test_stats;
`ifdef DCACHE_STATS_EN
    #1;
    checks++; if (stat_hits !== 32'(expHits)) begin
      errors++; $display("FAIL stat_hits: got %0d want %0d", stat_hits, expHits); end
    checks++; if (stat_misses !== 32'(expMisses)) begin
      errors++; $display("FAIL stat_misses: got %0d want %0d", stat_misses, expMisses); end
`endif
  endtask

  initial begin
    reset = 1'b1; address = 32'd0; writeData = 32'd0;
    MemRead = 1'b0; MemWrite = 1'b0; mem_rdata = 32'd0; mem_ready = 1'b0;
    test_reset();
    test_read_miss_fill();
    test_read_hit();
    test_no_request();
    test_write_hit();
    test_priority();
    test_write_miss();
    test_conflict();
    test_stats();
    test_reset_during_fill();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
